// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, parity modes and a frame-length helper.
// Imported by the transmitter today and intended for a matching receiver later.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Clock cycles occupied by one complete frame on the serial line.
   function automatic int frame_cycles(input int clk_div, input int data_bits,
                                       input int parity, input int stop_bits);
      return clk_div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO_SYNC-style read port: the FIFO presents a word with REQ, the consumer takes it with ACK.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] DATA_IN;
   logic                 REQ_IN;
   logic                 ACK_OUT;

   modport master (output DATA_IN, output REQ_IN, input ACK_OUT);
   modport slave  (input DATA_IN, input REQ_IN, output ACK_OUT);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: reloads at the start of every serial bit and flags the bit's final cycle.
module uart_baud_counter #(
   parameter int CLK_DIV = 16
) (
   input  logic CLK,
   input  logic RESET_IN,
   input  logic load_i,
   input  logic enable_i,
   output logic bit_end_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(CLK_DIV - 1);
      end else if (enable_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge CLK or posedge RESET_IN) begin
      if (RESET_IN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a FIFO read port: start bit, LSB-first data, optional parity, stop bits.
// A word waiting at the end of the last stop bit is taken immediately, giving gap-free frames.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic       CLK,
   input  logic       RESET_IN,
   uart_tx_if.slave   fifo_rd,
   output logic       TXD_OUT,
   output logic       BUSY_OUT
);

   if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || PARITY < 0 || PARITY > 2) begin : g_param_check
      $error("uart_tx: illegal parameter set");
   end

   localparam int BCW = $clog2(DATA_BITS);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]       bitcnt_q, bitcnt_d;
   logic                 par_q, par_d;
   logic                 txd_q, txd_d;
   logic                 ack;
   logic                 load;
   logic                 bit_end;

   uart_baud_counter #(.CLK_DIV(CLK_DIV)) u_baud (
      .CLK       (CLK),
      .RESET_IN  (RESET_IN),
      .load_i    (load),
      .enable_i  (state_q != ST_IDLE),
      .bit_end_o (bit_end)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      par_d    = par_q;
      ack      = 1'b0;
      load     = 1'b0;
      txd_d    = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (fifo_rd.REQ_IN) begin
               ack     = 1'b1;
               shreg_d = fifo_rd.DATA_IN;
               par_d   = 1'b0;
               state_d = ST_START;
               load    = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d  = ST_DATA;
               bitcnt_d = '0;
               load     = 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               par_d   = par_q ^ shreg_q[0];
               shreg_d = shreg_q >> 1;
               load    = 1'b1;
               if (bitcnt_q == BCW'(DATA_BITS - 1)) begin
                  state_d  = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                  bitcnt_d = '0;
               end else begin
                  bitcnt_d = bitcnt_q + BCW'(1);
               end
            end
         end
         ST_PAR: begin
            if (bit_end) begin
               state_d  = ST_STOP;
               bitcnt_d = '0;
               load     = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bitcnt_q == BCW'(STOP_BITS - 1)) begin
                  // Chain straight into the next frame when a word is already waiting.
                  if (fifo_rd.REQ_IN) begin
                     ack     = 1'b1;
                     shreg_d = fifo_rd.DATA_IN;
                     par_d   = 1'b0;
                     state_d = ST_START;
                     load    = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bitcnt_d = bitcnt_q + BCW'(1);
                  load     = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The line level is registered, so it is derived from the state being entered.
      unique case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shreg_d[0];
         ST_PAR:   txd_d = (PARITY == PAR_EVEN) ? par_d : ~par_d;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET_IN) begin
      if (RESET_IN) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         par_q    <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         par_q    <= par_d;
         txd_q    <= txd_d;
      end
   end

   assign fifo_rd.ACK_OUT = ack & ~RESET_IN;
   assign TXD_OUT         = txd_q;
   assign BUSY_OUT        = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that consumes words from a FIFO_SYNC-style read port (REQ/ACK, data valid while REQ is high) and drives an asynchronous serial line.
- Used to drain debug and trace FIFOs off-chip.
- Frame format: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
- Single clock domain. Bit timing comes from an integer clock divider.

Parameters:
- CLK_DIV, 16: CLK cycles per serial bit. Must be ≥ 2.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- CLK  in  1  clock.
- RESET_IN  in  1  asynchronous, active-high reset.
- DATA_IN  in  DATA_BITS  word to send; valid whenever REQ_IN is high.
- REQ_IN  in  1  word available (connects to the FIFO's READ_REQ_OUT).
- ACK_OUT  out  1  word consumed this cycle (connects to the FIFO's READ_ACK_IN). Combinational.
- TXD_OUT  out  1  serial line. Idle high. Registered.
- BUSY_OUT  out  1  high whenever a frame is in progress (state ≠ IDLE).

Behaviour:
- Reset (async): state = IDLE, TXD_OUT = 1, BUSY_OUT = 0, ACK_OUT = 0, baud counter = 0, bit counter = 0.
- States: IDLE, START, DATA, PAR, STOP.
- Baud counter runs in every non-IDLE state:
  - Loads CLK_DIV-1 on entry to each bit and decrements each cycle.
  - bit_end = (counter == 0).
  - Counter width is $clog2(CLK_DIV).
- ACK_OUT = REQ_IN & (state == IDLE | (state == STOP & bit_end & last stop bit)).
  - ACK is asserted for exactly one cycle per word; a word is never acked twice.
  - DATA_IN is sampled into the shift register on the ACK cycle.
- IDLE:
  - On ACK → START.
  - TXD_OUT = 0 from the next cycle (accept-to-start-edge latency = 1 cycle).
- START: TXD = 0 for CLK_DIV cycles. On bit_end → DATA, bit counter = 0.
- DATA:
  - TXD = shreg[0], held for CLK_DIV cycles.
  - On bit_end: shift right and increment the bit counter.
  - After bit DATA_BITS-1: go to PAR if PARITY ≠ 0, else STOP.
- Parity:
  - Accumulated as the XOR of the data bits while shifting.
  - Even parity sends XOR; odd parity sends ~XOR.
  - PAR lasts CLK_DIV cycles, then → STOP.
- STOP:
  - TXD = 1 for STOP_BITS × CLK_DIV cycles.
  - On the final bit_end: if ACK fires, go to START directly (zero idle gap between frames); else → IDLE.
- Frame length = (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × CLK_DIV cycles.
- REQ_IN dropping mid-frame has no effect on the current frame. DATA_IN is ignored outside ACK cycles.
- Reset mid-frame:
  - TXD_OUT returns to 1 immediately and the state goes to IDLE.
  - The in-flight word is discarded (it was already acked). No re-ack.
- Out-of-range parameters (CLK_DIV < 2, DATA_BITS outside 5..9, STOP_BITS not 1 or 2, PARITY > 2) are rejected by an elaboration-time assertion.

Decomposition:
- uart_pkg holds:
  - the state typedef (IDLE, START, DATA, PAR, STOP);
  - parity mode constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
  - the frame-length helper function.
- One sub-module: uart_baud_counter.
  - Inputs: CLK, RESET_IN, load, enable.
  - Output: bit_end.
  - Shared with a future uart_rx.

Test Plan:
- Idle with REQ_IN = 0 for 100 cycles → TXD_OUT stays 1, ACK_OUT stays 0, BUSY_OUT stays 0.
- CLK_DIV = 4, PARITY = 0, single word 0xA5 → ACK high for 1 cycle; TXD = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); BUSY drops after the stop bit.
- Back-to-back 0x00 then 0xFF with REQ held high → second ACK on the last stop cycle; second start edge exactly 40 cycles after the first; no idle cycle between frames.
- PARITY = 2 with 0x03 → parity bit 0. PARITY = 1 with 0x03 → parity bit 1. Frame length 44 cycles at CLK_DIV = 4.
- STOP_BITS = 2, 0x55 → TXD held high for 8 cycles after the last data bit before the next start.
- Pulse RESET_IN during data bit 3 → TXD = 1 in the same cycle; next REQ is acked from IDLE; the following frame is correct; only one ACK per word overall.
